// File: rtl/ysyx_23060184_exu_ctrl_if.sv
// Handshake and datapath bundle between the execute sequencer and its neighbours.
// Handshake: a transfer happens on a rising edge where valid & ready are both high; valid never waits on ready.
interface ysyx_23060184_exu_ctrl_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int PC_SRC_WIDTH = 2
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_multi;
    logic                    flush;
    logic                    opnd_we;
    logic [DATA_WIDTH-1:0]   alu_result;
    logic [DATA_WIDTH-1:0]   pc_target;
    logic [PC_SRC_WIDTH-1:0] pc_src;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_WIDTH-1:0]   out_result;
    logic [PC_SRC_WIDTH-1:0] out_pc_src;
    logic                    redirect;
    logic [DATA_WIDTH-1:0]   redirect_pc;
    logic                    busy;
    logic [1:0]              state;

    modport slave (
        input  in_valid, in_multi, flush, alu_result, pc_target, pc_src, out_ready,
        output in_ready, opnd_we, out_valid, out_result, out_pc_src, redirect,
               redirect_pc, busy, state
    );

    modport master (
        output in_valid, in_multi, flush, alu_result, pc_target, pc_src, out_ready,
        input  in_ready, opnd_we, out_valid, out_result, out_pc_src, redirect,
               redirect_pc, busy, state
    );
endinterface

// File: rtl/ysyx_23060184_exu_ctrl.sv
// Execute-stage sequencer: accepts decoded ops, waits out their latency, captures
// the datapath result and emits a one-cycle PC redirect for taken control transfers.
module ysyx_23060184_exu_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int PC_SRC_WIDTH = 2,
    parameter int MULTI_LAT    = 4,
    parameter int CNT_WIDTH    = 3
) (
    input logic                          clk,
    input logic                          rstn,
    ysyx_23060184_exu_ctrl_if.slave      ifc
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] MULTI_LOAD = CNT_WIDTH'(MULTI_LAT - 1);

    state_t                  state;
    logic [CNT_WIDTH-1:0]    cnt;
    logic                    out_valid_q;
    logic [DATA_WIDTH-1:0]   out_result_q;
    logic [PC_SRC_WIDTH-1:0] out_pc_src_q;
    logic [DATA_WIDTH-1:0]   target_q;
    logic                    redirect_q;
    logic [DATA_WIDTH-1:0]   redirect_pc_q;

    logic in_ready;
    logic acc;

    // Accepting in DONE overlaps the new op's operand load with the old op's handshake.
    always_comb begin
        in_ready = ~ifc.flush & ((state == IDLE) | ((state == DONE) & ifc.out_ready));
        acc      = ifc.in_valid & in_ready;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            cnt           <= '0;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_pc_src_q  <= '0;
            target_q      <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            redirect_q <= 1'b0;
            if (ifc.flush) begin
                state       <= IDLE;
                out_valid_q <= 1'b0;
                cnt         <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (acc) begin
                            state <= EXEC;
                            cnt   <= ifc.in_multi ? MULTI_LOAD : '0;
                        end
                    end
                    EXEC: begin
                        if (cnt != '0) begin
                            cnt <= cnt - CNT_WIDTH'(1);
                        end else begin
                            out_result_q <= ifc.alu_result;
                            out_pc_src_q <= ifc.pc_src;
                            target_q     <= ifc.pc_target;
                            out_valid_q  <= 1'b1;
                            state        <= DONE;
                        end
                    end
                    DONE: begin
                        if (out_valid_q && ifc.out_ready) begin
                            out_valid_q <= 1'b0;
                            if (out_pc_src_q != '0) begin
                                redirect_q    <= 1'b1;
                                redirect_pc_q <= target_q;
                            end
                            if (acc) begin
                                state <= EXEC;
                                cnt   <= ifc.in_multi ? MULTI_LOAD : '0;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign ifc.in_ready    = in_ready;
    assign ifc.opnd_we     = acc;
    assign ifc.out_valid   = out_valid_q;
    assign ifc.out_result  = out_result_q;
    assign ifc.out_pc_src  = out_pc_src_q;
    assign ifc.redirect    = redirect_q;
    assign ifc.redirect_pc = redirect_pc_q;
    assign ifc.busy        = (state != IDLE);
    assign ifc.state       = state;
endmodule

// File: tb/tb_ysyx_23060184_exu_ctrl.sv
// Directed bench for the execute sequencer: reset, single/multi-cycle ops,
// backpressure, branch redirect, flush and mid-DONE reset.
module tb_ysyx_23060184_exu_ctrl;
    localparam int DW = 32;
    localparam int PW = 2;

    logic clk;
    logic rstn;
    int   tests;
    int   fails;

    ysyx_23060184_exu_ctrl_if #(.DATA_WIDTH(DW), .PC_SRC_WIDTH(PW)) bus ();

    ysyx_23060184_exu_ctrl #(
        .DATA_WIDTH(DW), .PC_SRC_WIDTH(PW), .MULTI_LAT(4), .CNT_WIDTH(3)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .ifc (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rstn  = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_multi   = 1'b0;
        bus.flush      = 1'b0;
        bus.alu_result = '0;
        bus.pc_target  = '0;
        bus.pc_src     = '0;
        bus.out_ready  = 1'b0;
        step();
        step();

        // reset state
        check1("rst_out_valid", bus.out_valid, 1'b0);
        check32("rst_out_result", bus.out_result, 32'h0);
        check32("rst_out_pc_src", 32'(bus.out_pc_src), 32'h0);
        check1("rst_redirect", bus.redirect, 1'b0);
        check32("rst_redirect_pc", bus.redirect_pc, 32'h0);
        check1("rst_busy", bus.busy, 1'b0);
        check32("rst_state", 32'(bus.state), 32'd0);
        rstn = 1'b1;
        #1;
        check1("rst_in_ready", bus.in_ready, 1'b1);

        // single-cycle op
        bus.in_valid   = 1'b1;
        bus.alu_result = 32'h0000_0010;
        bus.out_ready  = 1'b1;
        #1;
        check1("s_opnd_we", bus.opnd_we, 1'b1);
        step();
        bus.in_valid = 1'b0;
        #1;
        check1("s_opnd_we_low", bus.opnd_we, 1'b0);
        check1("s_busy", bus.busy, 1'b1);
        check1("s_out_valid_exec", bus.out_valid, 1'b0);
        step();
        check1("s_out_valid", bus.out_valid, 1'b1);
        check32("s_out_result", bus.out_result, 32'h0000_0010);
        step();
        check1("s_out_valid_clr", bus.out_valid, 1'b0);
        check1("s_no_redirect", bus.redirect, 1'b0);
        check32("s_state_idle", 32'(bus.state), 32'd0);

        // multi-cycle op, then backpressure
        bus.in_valid   = 1'b1;
        bus.in_multi   = 1'b1;
        bus.alu_result = 32'h1234_5678;
        bus.pc_src     = 2'd0;
        bus.out_ready  = 1'b0;
        step();
        bus.in_multi = 1'b0;
        #1;
        check1("m_busy_c0", bus.busy, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            check1("m_in_ready_low", bus.in_ready, 1'b0);
            check1("m_opnd_we_low", bus.opnd_we, 1'b0);
            step();
            check1("m_out_valid_low", bus.out_valid, 1'b0);
            check1("m_busy", bus.busy, 1'b1);
        end
        step();
        check1("m_out_valid_c4", bus.out_valid, 1'b1);
        check1("m_busy_c4", bus.busy, 1'b1);
        check32("m_out_result", bus.out_result, 32'h1234_5678);
        bus.alu_result = 32'hdead_beef;
        bus.pc_src     = 2'd3;
        for (int k = 0; k < 5; k++) begin
            step();
            check1("bp_out_valid", bus.out_valid, 1'b1);
            check32("bp_out_result", bus.out_result, 32'h1234_5678);
            check32("bp_out_pc_src", 32'(bus.out_pc_src), 32'd0);
            check1("bp_in_ready", bus.in_ready, 1'b0);
        end
        bus.out_ready  = 1'b1;
        bus.alu_result = 32'h0000_0055;
        bus.pc_src     = 2'd0;
        #1;
        check1("b2b_in_ready", bus.in_ready, 1'b1);
        check1("b2b_opnd_we", bus.opnd_we, 1'b1);
        step();
        bus.in_valid = 1'b0;
        #1;
        check32("b2b_state_exec", 32'(bus.state), 32'd1);
        check1("b2b_out_valid_clr", bus.out_valid, 1'b0);
        check1("b2b_no_redirect", bus.redirect, 1'b0);
        step();
        check1("b2b_out_valid", bus.out_valid, 1'b1);
        check32("b2b_out_result", bus.out_result, 32'h0000_0055);
        step();
        check32("b2b_state_idle", 32'(bus.state), 32'd0);

        // taken branch redirect
        bus.in_valid  = 1'b1;
        bus.pc_src    = 2'd1;
        bus.pc_target = 32'h8000_0040;
        bus.out_ready = 1'b0;
        step();
        bus.in_valid = 1'b0;
        step();
        check1("br_out_valid", bus.out_valid, 1'b1);
        check32("br_out_pc_src", 32'(bus.out_pc_src), 32'd1);
        check1("br_redirect_early", bus.redirect, 1'b0);
        bus.out_ready = 1'b1;
        step();
        check1("br_redirect", bus.redirect, 1'b1);
        check32("br_redirect_pc", bus.redirect_pc, 32'h8000_0040);
        check1("br_out_valid_clr", bus.out_valid, 1'b0);
        step();
        check1("br_redirect_once", bus.redirect, 1'b0);

        // flush during a 4-cycle op
        bus.in_valid = 1'b1;
        bus.in_multi = 1'b1;
        bus.pc_src   = 2'd3;
        step();
        bus.in_valid = 1'b0;
        bus.in_multi = 1'b0;
        step();
        bus.flush = 1'b1;
        #1;
        check1("fl_in_ready", bus.in_ready, 1'b0);
        step();
        bus.flush = 1'b0;
        check32("fl_state_idle", 32'(bus.state), 32'd0);
        check1("fl_busy", bus.busy, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            check1("fl_out_valid", bus.out_valid, 1'b0);
            check1("fl_redirect", bus.redirect, 1'b0);
        end
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        #1;
        check1("fl_opnd_we", bus.opnd_we, 1'b0);
        step();
        check32("fl_no_accept", 32'(bus.state), 32'd0);

        // flush beats out_ready in DONE
        bus.flush    = 1'b0;
        bus.pc_src   = 2'd1;
        bus.out_ready = 1'b0;
        step();
        bus.in_valid = 1'b0;
        step();
        check1("fd_out_valid", bus.out_valid, 1'b1);
        bus.out_ready = 1'b1;
        bus.flush     = 1'b1;
        step();
        bus.flush = 1'b0;
        check1("fd_out_valid_clr", bus.out_valid, 1'b0);
        check1("fd_no_redirect", bus.redirect, 1'b0);
        step();
        check1("fd_no_redirect_late", bus.redirect, 1'b0);

        // reset pulse mid-DONE
        bus.in_valid  = 1'b1;
        bus.pc_src    = 2'd2;
        bus.pc_target = 32'h0000_1000;
        bus.out_ready = 1'b0;
        step();
        bus.in_valid = 1'b0;
        step();
        check1("rd_out_valid", bus.out_valid, 1'b1);
        check32("rd_out_pc_src", 32'(bus.out_pc_src), 32'd2);
        bus.out_ready = 1'b1;
        rstn          = 1'b0;
        #1;
        check1("rd_out_valid_clr", bus.out_valid, 1'b0);
        check1("rd_redirect", bus.redirect, 1'b0);
        check1("rd_busy", bus.busy, 1'b0);
        step();
        rstn = 1'b1;
        step();
        check1("rd_redirect_after", bus.redirect, 1'b0);
        check1("rd_out_valid_after", bus.out_valid, 1'b0);
        check1("rd_in_ready", bus.in_ready, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
